// File: rtl/fp27_pkg.sv
// Shared fp27 format definitions for the vector-op blocks:
// sign, 8-bit biased exponent and 18-bit mantissa with a hidden leading one.
package fp27_pkg;

    localparam int FP27_W   = 27;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 18;
    localparam int SIGN_BIT = 26;
    localparam int EXP_MSB  = 25;
    localparam int EXP_LSB  = 18;
    localparam int MAN_MSB  = 17;
    localparam int EXP_BIAS = 127;

    localparam logic [EXP_W-1:0] EXP_ZERO = '0;
    localparam logic [EXP_W-1:0] EXP_INF  = '1;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp27_t;

endpackage

// File: rtl/fp27_to_fixed_lane.sv
// One conversion lane: stage 1 holds sign and truncated magnitude,
// stage 2 holds the negated/saturated two's complement result.
module fp27_to_fixed_lane
    import fp27_pkg::*;
#(
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load1,
    input  logic              load2,
    input  logic [FP27_W-1:0] fp,
    output logic [OUT_W-1:0]  fix,
    output logic              sat
);

    localparam int WIDE_W = MAN_W + 1 + OUT_W + 1;

    localparam logic [OUT_W:0]   POS_LIMIT = {2'b00, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W:0]   NEG_LIMIT = {2'b01, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] POS_SAT   = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_SAT   = {1'b1, {(OUT_W-1){1'b0}}};

    fp27_t             f;
    logic [MAN_W:0]    mant;
    int                sh;
    logic [WIDE_W-1:0] wide;
    logic              big_c;
    logic [OUT_W:0]    mag_c;

    logic              s1_sign;
    logic              s1_big;
    logic [OUT_W:0]    s1_mag;

    logic              sat_c;
    logic [OUT_W-1:0]  fix_c;

    assign f    = fp27_t'(fp);
    assign mant = {1'b1, f.man};

    // Scaled value is mant * 2^(exp - bias - MAN_W + FRAC_BITS); the magnitude
    // keeps one bit above OUT_W so the -2^(OUT_W-1) case can be told apart.
    always_comb begin
        sh    = int'(f.exp) - EXP_BIAS - MAN_W + FRAC_BITS;
        wide  = '0;
        big_c = 1'b0;
        if (f.exp == EXP_INF) begin
            big_c = 1'b1;
        end else if (f.exp != EXP_ZERO) begin
            if (sh > OUT_W)
                big_c = 1'b1;
            else if (sh >= 0)
                wide = WIDE_W'(mant) << sh;
            else
                wide = WIDE_W'(mant) >> (-sh);
        end
        if (|wide[WIDE_W-1:OUT_W+1])
            big_c = 1'b1;
        mag_c = wide[OUT_W:0];
    end

    // NOTE: stage-1 datapath registers carry no reset; the top's valid bits
    // decide whether their contents are ever used.
    always_ff @(posedge clk) begin
        if (load1) begin
            s1_sign <= f.sign;
            s1_big  <= big_c;
            s1_mag  <= mag_c;
        end
    end

    always_comb begin
        sat_c = s1_big || (s1_sign ? (s1_mag > NEG_LIMIT) : (s1_mag > POS_LIMIT));
        if (sat_c)
            fix_c = s1_sign ? NEG_SAT : POS_SAT;
        else if (s1_sign)
            fix_c = ~s1_mag[OUT_W-1:0] + 1'b1;
        else
            fix_c = s1_mag[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fix <= '0;
            sat <= 1'b0;
        end else if (load2) begin
            fix <= fix_c;
            sat <= sat_c;
        end
    end

endmodule

// File: rtl/vec_fp_to_fixed.sv
// Converts an fp27 xyz vector plus tag to fixed point through a 2-stage
// pipeline with ready/valid handshakes on both sides.
module vec_fp_to_fixed
    import fp27_pkg::*;
#(
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = 8,
    parameter int TAG_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [FP27_W-1:0] i_x,
    input  logic [FP27_W-1:0] i_y,
    input  logic [FP27_W-1:0] i_z,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [OUT_W-1:0]  o_x,
    output logic [OUT_W-1:0]  o_y,
    output logic [OUT_W-1:0]  o_z,
    output logic [TAG_W-1:0]  o_tag,
    output logic [2:0]        o_sat,
    output logic              o_valid,
    input  logic              i_ready
);

    logic             run;
    logic             v1;
    logic             v2;
    logic [TAG_W-1:0] tag1;
    logic             adv1;
    logic             adv2;
    logic             accept;
    logic             load2;

    // run keeps o_ready low throughout reset and releases it one edge later.
    assign adv2    = !v2 || i_ready;
    assign adv1    = !v1 || adv2;
    assign o_ready = run && adv1;
    assign accept  = i_valid && o_ready;
    assign load2   = adv2 && v1;
    assign o_valid = v2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            run   <= 1'b0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            o_tag <= '0;
        end else begin
            run <= 1'b1;
            if (adv1)
                v1 <= accept;
            if (adv2)
                v2 <= v1;
            if (load2)
                o_tag <= tag1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept)
            tag1 <= i_tag;
    end

    fp27_to_fixed_lane #(.OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS)) u_lane_x (
        .clk(i_clk), .rst_n(i_rst_n), .load1(accept), .load2(load2),
        .fp(i_x), .fix(o_x), .sat(o_sat[0])
    );

    fp27_to_fixed_lane #(.OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS)) u_lane_y (
        .clk(i_clk), .rst_n(i_rst_n), .load1(accept), .load2(load2),
        .fp(i_y), .fix(o_y), .sat(o_sat[1])
    );

    fp27_to_fixed_lane #(.OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS)) u_lane_z (
        .clk(i_clk), .rst_n(i_rst_n), .load1(accept), .load2(load2),
        .fp(i_z), .fix(o_z), .sat(o_sat[2])
    );

endmodule

// File: tb/tb_vec_fp_to_fixed.sv
// Bench for vec_fp_to_fixed: real-arithmetic reference model, scoreboard
// queue checked every cycle, directed corner vectors and random traffic.
module tb_vec_fp_to_fixed;

    localparam int OUT_W     = 16;
    localparam int FRAC_BITS = 8;
    localparam int TAG_W     = 8;

    logic              clk;
    logic              rst_n;
    logic [26:0]       i_x, i_y, i_z;
    logic [TAG_W-1:0]  i_tag;
    logic              i_valid;
    logic              o_ready;
    logic [OUT_W-1:0]  o_x, o_y, o_z;
    logic [TAG_W-1:0]  o_tag;
    logic [2:0]        o_sat;
    logic              o_valid;
    logic              i_ready;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    logic mon_en = 1'b0;
    logic rst_q = 1'b1;
    logic hold = 1'b0;
    logic [58:0] held = '0;
    logic [58:0] sb[$];
    logic [7:0]  out_tags[$];

    vec_fp_to_fixed #(.OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS), .TAG_W(TAG_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_x(i_x), .i_y(i_y), .i_z(i_z), .i_tag(i_tag),
        .i_valid(i_valid), .o_ready(o_ready),
        .o_x(o_x), .o_y(o_y), .o_z(o_z), .o_tag(o_tag), .o_sat(o_sat),
        .o_valid(o_valid), .i_ready(i_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // {sat, fix}: value * 2^FRAC_BITS truncated toward zero, then saturated.
    function automatic logic [16:0] model(input logic [26:0] f);
        int   e;
        int   mag;
        real  v;
        logic [15:0] fix;
        e = int'(f[25:18]);
        if (e == 0) return 17'd0;
        if (e == 255) return f[26] ? {1'b1, 16'h8000} : {1'b1, 16'h7FFF};
        v = $floor((1.0 + real'(f[17:0]) / 262144.0) * $pow(2.0, real'(e - 127 + FRAC_BITS)));
        if (!f[26] && v > 32767.0) return {1'b1, 16'h7FFF};
        if (f[26] && v > 32768.0) return {1'b1, 16'h8000};
        mag = int'(v);
        fix = 16'(f[26] ? -mag : mag);
        return {1'b0, fix};
    endfunction

    function automatic logic [58:0] expect_of(input logic [26:0] x, y, z, input logic [7:0] tag);
        logic [16:0] mx, my, mz;
        mx = model(x);
        my = model(y);
        mz = model(z);
        return {mz[16], my[16], mx[16], tag, mz[15:0], my[15:0], mx[15:0]};
    endfunction

    function automatic logic [26:0] rand_fp();
        logic [7:0] e;
        int p;
        p = $urandom_range(9);
        if (p == 0)      e = 8'h00;
        else if (p == 1) e = 8'hFF;
        else if (p < 8)  e = 8'($urandom_range(150, 110));
        else             e = 8'($urandom);
        return {1'($urandom), e, 18'($urandom)};
    endfunction

    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       i_ready = 1'b1;
                1:       i_ready = 1'b0;
                default: i_ready = 1'($urandom_range(1));
            endcase
        end
    end

    always @(posedge clk) rst_q <= rst_n;

    // Scoreboard: every emitted vector is compared with the oldest accepted one.
    always @(negedge clk) begin
        int cnt;
        logic [58:0] act;
        logic [58:0] e;
        if (mon_en) begin
            act = {o_sat, o_tag, o_z, o_y, o_x};
            if (!rst_q) begin
                check("rst_valid", o_valid, 0);
                check("rst_sat", o_sat, 0);
                check("rst_data", {o_x, o_y, o_z, o_tag}, 0);
                check("rst_ready", o_ready, 0);
                sb.delete();
                hold <= 1'b0;
            end else begin
                cnt = sb.size();
                if (hold)
                    check("stall_hold", {o_valid, act}, {1'b1, held});
                check("ready", o_ready, !(cnt == 2 && !i_ready));
                if (o_valid && cnt == 0) begin
                    check("spurious_valid", o_valid, 0);
                end else if (o_valid && i_ready) begin
                    e = sb.pop_front();
                    check("emit", act, e);
                    out_tags.push_back(o_tag);
                end
                hold <= o_valid && !i_ready;
                held <= act;
                if (i_valid && o_ready)
                    sb.push_back(expect_of(i_x, i_y, i_z, i_tag));
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [26:0] x, y, z, input logic [7:0] tag);
        int   n;
        logic acc;
        n = 0;
        i_x = x;
        i_y = y;
        i_z = z;
        i_tag = tag;
        i_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc)
            check("accept_timeout", acc, 1);
    endtask

    task automatic send_and_check(input string name, input logic [26:0] x, y, z, input logic [7:0] tag,
                                  input logic [15:0] ex, ey, ez, input logic [2:0] es);
        send(x, y, z, tag);
        i_valid = 1'b0;
        @(negedge clk);
        check({name, "_lat"}, o_valid, 0);
        @(negedge clk);
        check({name, "_valid"}, o_valid, 1);
        check(name, {o_sat, o_tag, o_z, o_y, o_x}, {es, tag, ez, ey, ex});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        ready_mode = 0;
        while ((sb.size() != 0 || o_valid) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", sb.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_valid = 1'b0;
        i_x = '0;
        i_y = '0;
        i_z = '0;
        i_tag = '0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_held_low", o_ready, 0);
        @(negedge clk);
        check("ready_after_reset", o_ready, 1);
        @(posedge clk);
        #1;

        check("model_one",     model(27'h1FC0000), 17'h00100);
        check("model_m2p5",    model(27'h6010000), 17'h0FD80);
        check("model_200",     model(27'h21A4000), 17'h17FFF);
        check("model_m200",    model(27'h61A4000), 17'h18000);
        check("model_inf",     model(27'h3FC0000), 17'h17FFF);
        check("model_exp0",    model(27'h003FFFF), 17'h00000);
        check("model_tiny",    model(27'h1D40000), 17'h00000);
        check("model_maxpos",  model(27'h217FFF0), 17'h07FFF);
        check("model_minneg",  model(27'h6180000), 17'h08000);
        check("model_p128",    model(27'h2180000), 17'h17FFF);

        send_and_check("basic", 27'h1FC0000, 27'h6010000, 27'h0000000, 8'h11,
                       16'h0100, 16'hFD80, 16'h0000, 3'b000);
        send_and_check("sat",   27'h21A4000, 27'h61A4000, 27'h3FC0000, 8'h22,
                       16'h7FFF, 16'h8000, 16'h7FFF, 3'b111);
        send_and_check("tiny",  27'h003FFFF, 27'h1D40000, 27'h5FC0000, 8'h33,
                       16'h0000, 16'h0000, 16'hFF00, 3'b000);
        send_and_check("edge",  27'h217FFF0, 27'h6180000, 27'h2180000, 8'h44,
                       16'h7FFF, 16'h8000, 16'h7FFF, 3'b100);

        // Back-to-back tags 0..9 under random downstream stalls.
        out_tags.delete();
        ready_mode = 2;
        for (int t = 0; t < 10; t++)
            send(rand_fp(), rand_fp(), rand_fp(), 8'(t));
        i_valid = 1'b0;
        drain();
        check("tag_count", out_tags.size(), 10);
        for (int t = 0; t < 10; t++)
            if (t < out_tags.size())
                check("tag_order", out_tags[t], t);

        // Two vectors stuck behind i_ready=0, then a one-cycle reset.
        ready_mode = 1;
        @(posedge clk);
        #1;
        send(27'h1FC0000, 27'h21A4000, 27'h3FC0000, 8'hA0);
        send(27'h6010000, 27'h61A4000, 27'h3FC0000, 8'hA1);
        i_valid = 1'b0;
        @(negedge clk);
        check("full_ready", o_ready, 0);
        check("full_valid", o_valid, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_sat", o_sat, 0);
        ready_mode = 0;
        @(posedge clk);
        #1;
        send_and_check("after_rst", 27'h6010000, 27'h1FC0000, 27'h0000000, 8'h55,
                       16'hFD80, 16'h0100, 16'h0000, 3'b000);

        // Random traffic with random gaps and random stalls.
        ready_mode = 2;
        for (int k = 0; k < 1000; k++) begin
            if ($urandom_range(3) == 0) begin
                i_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send(rand_fp(), rand_fp(), rand_fp(), 8'($urandom));
        end
        i_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
